lc3b_dual_port_mem_responder: RTL and testbench
===============================================

Name: lc3b_dual_port_mem_responder

Overview:
- Memory-side responder for the two 16-bit request ports (A: instruction fetch, B: data access) that the CPU datapath drives: read, write, wmask, address, wdata in; resp, rdata out.
- Holds a word-addressed backing array shared by both ports.
- Runs an independent fixed-latency handshake FSM per port.
- Used as the memory model under the pipelined core and as the stand-in for the cache hierarchy during datapath bring-up.

Parameters:
ADDR_BITS, 12, number of word-index bits; array depth = 2**ADDR_BITS 16-bit words.
LATENCY, 2, cycles from request acceptance to resp; legal range 1..15.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
read_a  input  1  port A read request
write_a  input  1  port A write request
wmask_a  input  2  port A byte enables; bit0 = low byte, bit1 = high byte
address_a  input  16  port A byte address
wdata_a  input  16  port A write data
resp_a  output  1  port A completion strobe, one cycle wide
rdata_a  output  16  port A read data, registered
read_b, write_b, wmask_b, address_b, wdata_b  input  1/1/2/16/16  port B, same meaning as port A
resp_b  output  1  port B completion strobe
rdata_b  output  16  port B read data, registered
proto_err  output  2  sticky error flags; bit0 = port A, bit1 = port B

Behaviour:
- Reset (reset_n low, asynchronous): both FSMs go to IDLE; resp_a, resp_b, rdata_a, rdata_b and proto_err go to 0. The array is not reset; its contents are preserved across reset.
- Word index: address[ADDR_BITS:1]. address[0] and bits above ADDR_BITS+1 are ignored, so accesses wrap modulo the array depth.
- Per-port FSM states: IDLE, BUSY.
  - IDLE: if read or write is high at a rising edge, accept the request, load the counter with LATENCY-1 and enter BUSY.
  - BUSY: decrement the counter while it is nonzero. At counter == 0, resp is high for that cycle (one cycle only), and the FSM returns to IDLE on the next edge.
- Timing: a request accepted at edge t produces resp in cycle t+LATENCY. Back-to-back requests complete every LATENCY+1 cycles.
- After resp, a request still asserted in the following cycle is treated as a new request (new acceptance, full LATENCY).
- Address, wmask and wdata are sampled at the resp-cycle edge, not at acceptance. The initiator holds them stable for the whole transaction.
- Read:
  - rdata is loaded from the array at the edge entering the resp cycle and holds until the next read response on that port.
  - Write responses do not change rdata.
- Write: enabled bytes are committed at the edge that ends the resp cycle. wmask 2'b00 completes the handshake with no array change.
- Request dropped mid-transaction (read and write both low while in BUSY): FSM returns to IDLE at the next edge, with no resp and no array update.
- read and write both high: write is performed, the read is ignored, and the port's proto_err bit is set. proto_err clears only on reset.
- Port collisions on the same word:
  - Port A read and port B write in the same resp cycle: rdata_a returns the old data.
  - Both ports write in the same cycle: port B's enabled bytes win; port A's non-overlapping bytes are still written.
  - A write completing in cycle c is visible to any read whose resp cycle is c+1 or later.
- Ports are fully independent; neither port ever stalls the other.

Test Plan:
- Reset/idle: hold reset_n=0 for 3 cycles, release -> resp_a=resp_b=0, rdata_a=rdata_b=16'h0000, proto_err=2'b00; assert reset_n=0 mid-BUSY -> resp never pulses, FSM in IDLE.
- Latency: LATENCY=2; port B write 16'hBEEF to 16'h0040, wmask 2'b11, request high from edge 0 -> resp_b high only in cycle 2; then port A read 16'h0040 -> resp_a high 2 cycles after acceptance, rdata_a=16'hBEEF.
- Byte masks: word 16'h0040 = 16'hBEEF; write wdata 16'h1234 with wmask 2'b01 -> readback 16'hBE34; then wmask 2'b10 -> 16'h1234; then wmask 2'b00 -> resp pulses, data stays 16'h1234.
- Collision: both ports' resp cycles coincide, A reads and B writes 16'hAAAA to word 5 (old value 16'h5555) -> rdata_a=16'h5555; next A read -> 16'hAAAA. Both write the same word, A=16'h1111, B=16'h2222, full masks -> word=16'h2222.
- Back-to-back and wrap: read_a held high for 9 cycles, LATENCY=2 -> resp_a in cycles 2, 5, 8. Address 16'h2002 with ADDR_BITS=12 aliases word index 1 (address 16'h0002).
- Abort and error: drop read_b after 1 cycle -> no resp_b, next request gets full latency. read_b=write_b=1 -> write performed, resp_b pulses, proto_err=2'b10 held until reset.

Source files
------------

// File: rtl/lc3b_dual_port_mem_responder.sv
// Two-port word memory with an independent fixed-latency IDLE/BUSY handshake per port; resp LATENCY cycles after acceptance.
// Never stalls a port; a dropped request aborts silently, read+write together performs the write and flags proto_err.
module lc3b_dual_port_mem_responder #(
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        read_a,
    input  logic        write_a,
    input  logic [1:0]  wmask_a,
    input  logic [15:0] address_a,
    input  logic [15:0] wdata_a,
    output logic        resp_a,
    output logic [15:0] rdata_a,
    input  logic        read_b,
    input  logic        write_b,
    input  logic [1:0]  wmask_b,
    input  logic [15:0] address_b,
    input  logic [15:0] wdata_b,
    output logic        resp_b,
    output logic [15:0] rdata_b,
    output logic [1:0]  proto_err
);
    localparam int         DEPTH  = 1 << ADDR_BITS;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    logic [15:0]          mem [DEPTH];

    logic                 rd     [2];
    logic                 wr     [2];
    logic [1:0]           msk    [2];
    logic [ADDR_BITS-1:0] idx    [2];
    logic [15:0]          wdat   [2];

    state_t               state_q [2];
    state_t               state_d [2];
    logic [3:0]           cnt_q   [2];
    logic [3:0]           cnt_d   [2];
    logic                 resp    [2];
    logic                 load    [2];
    logic                 commit  [2];
    logic [15:0]          fwd     [2];
    logic [15:0]          rdata_q [2];
    logic [1:0]           err_q;
    logic [1:0]           err_d;
    logic                 unused_addr_bits;

    assign rd[0]   = read_a;
    assign wr[0]   = write_a;
    assign msk[0]  = wmask_a;
    assign idx[0]  = address_a[ADDR_BITS:1];
    assign wdat[0] = wdata_a;
    assign rd[1]   = read_b;
    assign wr[1]   = write_b;
    assign msk[1]  = wmask_b;
    assign idx[1]  = address_b[ADDR_BITS:1];
    assign wdat[1] = wdata_b;

    assign unused_addr_bits = ^{address_a[15:ADDR_BITS+1], address_a[0],
                                address_b[15:ADDR_BITS+1], address_b[0]};

    always_comb begin
        err_d = err_q;
        for (int p = 0; p < 2; p++) begin
            state_d[p] = state_q[p];
            cnt_d[p]   = cnt_q[p];
            resp[p]    = 1'b0;
            case (state_q[p])
                IDLE: begin
                    if (rd[p] || wr[p]) begin
                        state_d[p] = BUSY;
                        cnt_d[p]   = LAT_M1;
                    end
                end
                BUSY: begin
                    if (!(rd[p] || wr[p])) begin
                        state_d[p] = IDLE;
                    end else if (cnt_q[p] != 4'd0) begin
                        cnt_d[p] = cnt_q[p] - 4'd1;
                    end else begin
                        resp[p]    = 1'b1;
                        state_d[p] = IDLE;
                    end
                end
            endcase
            if (rd[p] && wr[p]) begin
                err_d[p] = 1'b1;
            end
            // Read data is captured on the edge that enters the resp cycle.
            load[p]   = (state_d[p] == BUSY) && (cnt_d[p] == 4'd0) && rd[p] && !wr[p];
            commit[p] = resp[p] && wr[p];
        end
    end

    // A write committing on the same edge a read is captured must be visible to that read;
    // port B is merged last so its bytes win, matching the array update order.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            fwd[p] = mem[idx[p]];
            for (int q = 0; q < 2; q++) begin
                if (commit[q] && (idx[q] == idx[p])) begin
                    if (msk[q][0]) fwd[p][7:0]  = wdat[q][7:0];
                    if (msk[q][1]) fwd[p][15:8] = wdat[q][15:8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int q = 0; q < 2; q++) begin
            if (commit[q]) begin
                if (msk[q][0]) mem[idx[q]][7:0]  <= wdat[q][7:0];
                if (msk[q][1]) mem[idx[q]][15:8] <= wdat[q][15:8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= IDLE;
                cnt_q[p]   <= 4'd0;
                rdata_q[p] <= 16'h0000;
            end
            err_q <= 2'b00;
        end else begin
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= state_d[p];
                cnt_q[p]   <= cnt_d[p];
                if (load[p]) rdata_q[p] <= fwd[p];
            end
            err_q <= err_d;
        end
    end

    assign resp_a    = resp[0];
    assign resp_b    = resp[1];
    assign rdata_a   = rdata_q[0];
    assign rdata_b   = rdata_q[1];
    assign proto_err = err_q;

endmodule

// File: tb/tb_lc3b_dual_port_mem_responder.sv
// Randomized + directed bench for the dual-port responder; expected responses are queued per port by a
// transaction-level model and a negedge monitor matches them against resp/rdata/proto_err.
module tb_lc3b_dual_port_mem_responder;
    localparam int AB  = 12;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        read_a, write_a, read_b, write_b;
    logic [1:0]  wmask_a, wmask_b;
    logic [15:0] address_a, wdata_a, address_b, wdata_b;
    logic        resp_a, resp_b;
    logic [15:0] rdata_a, rdata_b;
    logic [1:0]  proto_err;

    lc3b_dual_port_mem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .read_a(read_a), .write_a(write_a), .wmask_a(wmask_a), .address_a(address_a), .wdata_a(wdata_a),
        .resp_a(resp_a), .rdata_a(rdata_a),
        .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b), .address_b(address_b), .wdata_b(wdata_b),
        .resp_b(resp_b), .rdata_b(rdata_b),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 none, 1 read, 2 write, 3 read+write
    typedef struct {int kind; logic [15:0] addr; logic [15:0] wdata; logic [1:0] mask;} op_t;
    typedef struct {int cyc; logic [15:0] rdata; logic err;} exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [15:0] mdl [0:(1<<AB)-1];
    logic [15:0] last_rd [2];
    logic [1:0]  err_m;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    function automatic op_t mk(int k, logic [15:0] a, logic [15:0] d, logic [1:0] m);
        op_t o;
        o.kind = k; o.addr = a; o.wdata = d; o.mask = m;
        return o;
    endfunction

    function automatic int widx(logic [15:0] a);
        return (int'(a) >> 1) % (1 << AB);
    endfunction

    // phase 0: reads only, 1: writes only, 2: either
    task automatic do_port(int p, op_t o, int rc, int phase);
        exp_t e;
        int   i;
        if (o.kind == 0) return;
        i = widx(o.addr);
        if (o.kind == 1) begin
            if (phase == 1) return;
            last_rd[p] = mdl[i];
        end else begin
            if (phase == 0) return;
            if (o.mask[0]) mdl[i][7:0]  = o.wdata[7:0];
            if (o.mask[1]) mdl[i][15:8] = o.wdata[15:8];
            if (o.kind == 3) err_m[p] = 1'b1;
        end
        e.cyc = rc; e.rdata = last_rd[p]; e.err = err_m[p];
        if (p == 0) qa.push_back(e); else qb.push_back(e);
    endtask

    task automatic set_port(int p, op_t o, bit on);
        logic r, w;
        r = on && (o.kind == 1 || o.kind == 3);
        w = on && (o.kind >= 2);
        if (p == 0) begin
            read_a = r; write_a = w; wmask_a = o.mask; address_a = o.addr; wdata_a = o.wdata;
        end else begin
            read_b = r; write_b = w; wmask_b = o.mask; address_b = o.addr; wdata_b = o.wdata;
        end
    endtask

    // Each port raises its request at cycle offset oa/ob and holds it through its resp cycle.
    task automatic run_pair(op_t a, op_t b, int oa, int ob);
        int base, ra, rb, last;
        @(posedge clk); #1;
        base = cyc;
        ra = base + oa + LAT;
        rb = base + ob + LAT;
        if (ra < rb) begin
            do_port(0, a, ra, 2); do_port(1, b, rb, 2);
        end else if (rb < ra) begin
            do_port(1, b, rb, 2); do_port(0, a, ra, 2);
        end else begin
            do_port(0, a, ra, 0); do_port(1, b, rb, 0);
            do_port(0, a, ra, 1); do_port(1, b, rb, 1);
        end
        last = ((oa > ob) ? oa : ob) + LAT + 1;
        for (int t = 0; t <= last; t++) begin
            set_port(0, a, (t >= oa) && (t <= oa + LAT));
            set_port(1, b, (t >= ob) && (t <= ob + LAT));
            if (t < last) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic b2b(op_t o, int n);
        int base;
        @(posedge clk); #1;
        base = cyc;
        for (int k = 0; k < n; k++) do_port(0, o, base + LAT + k * (LAT + 1), 2);
        for (int t = 0; t < n * (LAT + 1); t++) begin
            set_port(0, o, 1'b1);
            @(posedge clk); #1;
        end
        set_port(0, o, 1'b0);
    endtask

    function automatic op_t rnd_op();
        int          k, r;
        logic [15:0] ad;
        r = $urandom_range(0, 9);
        k = (r < 2) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
        ad = {3'($urandom_range(0, 7)), 12'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
        return mk(k, ad, 16'($urandom), 2'($urandom_range(0, 3)));
    endfunction

    task automatic mon_port(int p, logic r, logic [15:0] rd, logic er);
        exp_t e;
        int   n;
        n = (p == 0) ? qa.size() : qb.size();
        if (r) begin
            if (n == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_resp port%0d cyc=%0d: got resp=1 want 0", p, cyc);
            end else begin
                if (p == 0) e = qa.pop_front(); else e = qb.pop_front();
                chk($sformatf("resp_cycle_p%0d", p), cyc, e.cyc);
                chk($sformatf("rdata_p%0d", p), {16'h0, rd}, {16'h0, e.rdata});
                chk($sformatf("proto_err_p%0d", p), {31'h0, er}, {31'h0, e.err});
            end
        end else if (n > 0) begin
            if (p == 0) e = qa[0]; else e = qb[0];
            if (e.cyc <= cyc) begin
                if (p == 0) void'(qa.pop_front()); else void'(qb.pop_front());
                checks++; errors++;
                $display("FAIL missing_resp port%0d cyc=%0d: got resp=0 want 1", p, cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            mon_port(0, resp_a, rdata_a, proto_err[0]);
            mon_port(1, resp_b, rdata_b, proto_err[1]);
        end
    end

    task automatic check_reset_outputs();
        @(negedge clk);
        chk("rst_resp_a", {31'h0, resp_a}, 32'h0);
        chk("rst_resp_b", {31'h0, resp_b}, 32'h0);
        chk("rst_rdata_a", {16'h0, rdata_a}, 32'h0);
        chk("rst_rdata_b", {16'h0, rdata_b}, 32'h0);
        chk("rst_proto_err", {30'h0, proto_err}, 32'h0);
    endtask

    op_t none;

    initial begin
        none = mk(0, 16'h0, 16'h0, 2'b00);
        last_rd[0] = 16'h0; last_rd[1] = 16'h0; err_m = 2'b00;
        set_port(0, none, 1'b0);
        set_port(1, none, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check_reset_outputs();

        run_pair(none, mk(2, 16'h0040, 16'hBEEF, 2'b11), 0, 0);
        run_pair(mk(1, 16'h0040, 16'h0, 2'b00), none, 0, 0);

        run_pair(mk(2, 16'h0040, 16'h1234, 2'b01), none, 0, 0);
        run_pair(mk(1, 16'h0040, 16'h0, 2'b00), none, 0, 0);
        run_pair(mk(2, 16'h0040, 16'h1234, 2'b10), none, 0, 0);
        run_pair(mk(1, 16'h0040, 16'h0, 2'b00), none, 0, 0);
        run_pair(mk(2, 16'h0040, 16'hFFFF, 2'b00), none, 0, 0);
        run_pair(mk(1, 16'h0040, 16'h0, 2'b00), none, 0, 0);

        run_pair(mk(2, 16'h000A, 16'h5555, 2'b11), none, 0, 0);
        run_pair(mk(1, 16'h000A, 16'h0, 2'b00), mk(2, 16'h000A, 16'hAAAA, 2'b11), 0, 0);
        run_pair(mk(1, 16'h000A, 16'h0, 2'b00), none, 0, 0);
        run_pair(mk(2, 16'h000A, 16'h1111, 2'b11), mk(2, 16'h000A, 16'h2222, 2'b11), 0, 0);
        run_pair(mk(1, 16'h000A, 16'h0, 2'b00), none, 0, 0);
        run_pair(mk(2, 16'h000A, 16'h1111, 2'b11), mk(2, 16'h000A, 16'h2222, 2'b01), 0, 0);
        run_pair(none, mk(1, 16'h000A, 16'h0, 2'b00), 0, 0);

        // Write finishing one cycle before a read of the same word must be seen by it.
        run_pair(mk(1, 16'h000A, 16'h0, 2'b00), mk(2, 16'h000A, 16'h7E57, 2'b11), 1, 0);
        run_pair(mk(2, 16'h000A, 16'hC0DE, 2'b11), mk(1, 16'h000A, 16'h0, 2'b00), 0, 1);

        b2b(mk(1, 16'h0040, 16'h0, 2'b00), 3);

        run_pair(mk(2, 16'h2002, 16'h0A1A, 2'b11), none, 0, 0);
        run_pair(mk(1, 16'h0002, 16'h0, 2'b00), none, 0, 0);

        @(posedge clk); #1;
        set_port(1, mk(1, 16'h0040, 16'h0, 2'b00), 1'b1);
        @(posedge clk); #1;
        set_port(1, none, 1'b0);
        repeat (LAT + 2) @(posedge clk);
        run_pair(none, mk(1, 16'h0040, 16'h0, 2'b00), 0, 0);

        run_pair(none, mk(3, 16'h0040, 16'h4321, 2'b11), 0, 0);
        run_pair(none, mk(1, 16'h0040, 16'h0, 2'b00), 0, 0);
        @(negedge clk);
        chk("proto_err_sticky", {30'h0, proto_err}, {30'h0, err_m});

        for (int i = 0; i < 8; i++)
            run_pair(mk(2, 16'(2 * i), 16'($urandom), 2'b11), none, 0, 0);
        for (int n = 0; n < 40; n++)
            run_pair(rnd_op(), rnd_op(), $urandom_range(0, 1), $urandom_range(0, 1));

        @(posedge clk); #1;
        set_port(0, mk(1, 16'h0040, 16'h0, 2'b00), 1'b1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        set_port(0, none, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        last_rd[0] = 16'h0; last_rd[1] = 16'h0; err_m = 2'b00;
        check_reset_outputs();
        run_pair(mk(1, 16'h0040, 16'h0, 2'b00), mk(1, 16'h0006, 16'h0, 2'b00), 0, 0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("qa_drained", qa.size(), 32'h0);
        chk("qb_drained", qb.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
